i3c_sdr_initiator: RTL



---
 rtl/i3c_sdr_initiator.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/i3c_sdr_initiator.sv
// i3c_sdr_initiator
// Controller-side single-byte initiator for the I3C/I2C bit layer. Issues
// START, {addr, rnw}, ACK slot, one data byte, ACK slot, STOP, then idles
// the bus for one half period before reporting completion.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   scl_i / sda_i          sampled bus levels
//   scl_o, scl_en_o        SCL drive (value always 0, enable pulls low)
//   sda_o, sda_en_o        SDA drive (value always 0, enable pulls low)
//   cmd_valid_i/ready_o    one-deep command handshake (ready only in IDLE)
//   cmd_addr_i/rnw_i/wdata_i  command fields, captured on accept
//   resp_valid_o           one-cycle completion pulse
//   resp_rdata_o           read byte, held until the next read response
//   resp_nack_o            address NACK, or data NACK on a write
//
// Build option: define I3C_INIT_CLOCK_STRETCH_EN to let a target stretch
// SCL; the high-phase counter then waits while scl_i reads 0.

module i3c_sdr_initiator #(
    parameter int HALF_PERIOD = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_en_o,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_en_o,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [6:0] cmd_addr_i,
    input  logic       cmd_rnw_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       resp_valid_o,
    output logic [7:0] resp_rdata_o,
    output logic       resp_nack_o
);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, FREE
    } state_t;

    localparam logic [7:0] PHASE_LAST = 8'(HALF_PERIOD - 1);
    // SDA is registered, so the update edge is one cycle before the low-phase
    // cycle floor(H/2) in which the new level must appear.
    localparam logic [7:0] SDA_EDGE   = 8'(HALF_PERIOD / 2 - 1);

    state_t     state_q, state_d;
    logic [7:0] phase_cnt_q;
    logic       high_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] tx_shift_q;
    logic [7:0] rx_shift_q;
    logic [7:0] wdata_q;
    logic       rnw_q;
    logic       nack_q;
    logic       sda_en_q;

    logic accept;
    logic bit_phases;
    logic advance;
    logic phase_done;
    logic bit_end;
    logic sda_update;

    assign accept     = (state_q == IDLE) && cmd_valid_i;
    // States built from SCL low/high bit periods (STOP shares the shape).
    assign bit_phases = state_q inside {ADDR, ADDR_ACK, DATA, DATA_ACK, STOP};

`ifdef I3C_INIT_CLOCK_STRETCH_EN
    assign advance = !(bit_phases && high_q && !scl_i);
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign advance    = 1'b1;
`endif

    assign phase_done = (state_q != IDLE) && advance && (phase_cnt_q == PHASE_LAST);
    assign bit_end    = bit_phases && high_q && phase_done;
    assign sda_update = bit_phases && !high_q && (phase_cnt_q == SDA_EDGE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cmd_valid_i) state_d = START;
            START:    if (phase_done) state_d = ADDR;
            ADDR:     if (bit_end && bit_cnt_q == 3'd7) state_d = ADDR_ACK;
            ADDR_ACK: if (bit_end) state_d = sda_i ? STOP : DATA;
            DATA:     if (bit_end && bit_cnt_q == 3'd7) state_d = DATA_ACK;
            DATA_ACK: if (bit_end) state_d = STOP;
            STOP:     if (bit_end) state_d = FREE;
            FREE:     if (phase_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        scl_en_o     = bit_phases && !high_q;
        sda_en_o     = sda_en_q;
        cmd_ready_o  = (state_q == IDLE);
        resp_valid_o = (state_q == FREE) && phase_done;
    end

    assign scl_o = 1'b0;
    assign sda_o = 1'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_cnt_q  <= '0;
            high_q       <= 1'b0;
            bit_cnt_q    <= '0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            wdata_q      <= '0;
            rnw_q        <= 1'b0;
            nack_q       <= 1'b0;
            sda_en_q     <= 1'b0;
            resp_rdata_o <= '0;
            resp_nack_o  <= 1'b0;
        end else begin
            if (state_q == IDLE || phase_done) begin
                phase_cnt_q <= '0;
            end else if (advance) begin
                phase_cnt_q <= phase_cnt_q + 8'd1;
            end

            // Every new state begins in its low (or only) phase.
            if (state_d != state_q) begin
                high_q <= 1'b0;
            end else if (bit_phases && phase_done) begin
                high_q <= !high_q;
            end

            if (accept) begin
                tx_shift_q <= {cmd_addr_i, cmd_rnw_i};
                wdata_q    <= cmd_wdata_i;
                rnw_q      <= cmd_rnw_i;
                nack_q     <= 1'b0;
                bit_cnt_q  <= '0;
                sda_en_q   <= 1'b1;
            end

            if (sda_update) begin
                case (state_q)
                    ADDR:    sda_en_q <= !tx_shift_q[7];
                    DATA:    sda_en_q <= !rnw_q && !tx_shift_q[7];
                    STOP:    sda_en_q <= 1'b1;
                    default: sda_en_q <= 1'b0;
                endcase
            end

            if (bit_end) begin
                case (state_q)
                    ADDR: begin
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                    end
                    ADDR_ACK: begin
                        nack_q     <= sda_i;
                        tx_shift_q <= wdata_q;
                    end
                    DATA: begin
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        if (rnw_q) rx_shift_q <= {rx_shift_q[6:0], sda_i};
                    end
                    DATA_ACK: begin
                        if (!rnw_q) nack_q <= sda_i;
                    end
                    STOP:    sda_en_q <= 1'b0;
                    default: ;
                endcase
            end

            if (resp_valid_o) begin
                resp_nack_o <= nack_q;
                if (rnw_q) resp_rdata_o <= rx_shift_q;
            end
        end
    end

endmodule
